// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART TX arbitration path.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first set request at or after ptr, wrapping at NUM_REQ-1.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  logic [2*NUM_REQ-1:0] req_2x;
  logic [NUM_REQ-1:0]   req_rot;
  int                   sum;

  // Doubling the vector turns the wrap-around search into a plain shift.
  always_comb begin
    req_2x    = {req, req};
    req_rot   = NUM_REQ'(req_2x >> ptr);
    idx       = '0;
    any_valid = 1'b0;
    sum       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && req_rot[k]) begin
        any_valid = 1'b1;
        sum       = int'(ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        idx       = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Locks the TX FIFO write port to one byte-stream requester per message,
// round-robin between messages, with an idle timeout that revokes a stuck grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         reqValid,
  input  logic [NUM_REQ*8-1:0]       reqData,
  input  logic [NUM_REQ-1:0]         reqLast,
  output logic [NUM_REQ-1:0]         reqReady,
  input  logic                       txFull,
  output logic                       wrEn,
  output logic [7:0]                 wrData,
  output logic [$clog2(NUM_REQ)-1:0] grantId,
  output logic                       busy,
  output logic                       timeoutPulse
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          tmo_q, tmo_d;

  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          xfer;
  logic [GW-1:0] next_rr;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_rr_select (
    .req       (reqValid),
    .ptr       (rr_q),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = reqValid[i];
        sel_last  = reqLast[i];
        sel_data  = reqData[i*8 +: 8];
      end
    end
  end

  assign xfer    = (state_q == LOCK) && sel_valid && !txFull;
  assign next_rr = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCK;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        // A completing transfer wins over the idle timeout.
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_data_d = sel_data;
          cnt_d     = '0;
          if (sel_last) begin
            state_d = IDLE;
            rr_d    = next_rr;
          end
        end else if (!sel_valid) begin
          if (cnt_q == CNT_TC) begin
            state_d = IDLE;
            rr_d    = next_rr;
            tmo_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqReady[i] = (state_q == LOCK) && (grant_q == GW'(i)) && !txFull;
    end
    wrEn         = wr_en_q;
    wrData       = wr_data_q;
    grantId      = grant_q;
    busy         = (state_q == LOCK);
    timeoutPulse = tmo_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand sequences, randomized run vs model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  reqValid, reqLast, reqReady;
  logic [31:0] reqData;
  logic        txFull, wrEn, busy, timeoutPulse;
  logic [7:0]  wrData;
  logic [1:0]  grantId;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .reqValid     (reqValid),
    .reqData      (reqData),
    .reqLast      (reqLast),
    .reqReady     (reqReady),
    .txFull       (txFull),
    .wrEn         (wrEn),
    .wrData       (wrData),
    .grantId      (grantId),
    .busy         (busy),
    .timeoutPulse (timeoutPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        tf;
    logic [3:0]  rdy;
    logic        we;
    logic [7:0]  wd;
    logic        bz;
    logic [1:0]  g;
    logic        tp;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: owner=-1 means nobody holds the port.
  int         m_owner, m_ptr, m_last_grant, m_idle;
  logic       m_wr_en, m_pulse;
  logic [7:0] m_wr_data;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic tf,
                              logic [3:0] rdy, logic we, logic [7:0] wd, logic bz,
                              logic [1:0] g, logic tp);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.tf = tf; r.rdy = rdy;
    r.we = we; r.wd = wd; r.bz = bz; r.g = g; r.tp = tp;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_last_grant = 0; m_idle = 0;
    m_wr_en = 1'b0; m_wr_data = 8'h00; m_pulse = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    reqValid = '0; reqData = '0; reqLast = '0; txFull = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic apply_vec(input vec_t r, input int idx);
    @(negedge clk);
    reqValid = r.v; reqData = r.d; reqLast = r.l; txFull = r.tf;
    #1;
    chk($sformatf("vec%0d.reqReady", idx), reqReady, r.rdy);
    chk($sformatf("vec%0d.wrEn", idx), wrEn, r.we);
    chk($sformatf("vec%0d.wrData", idx), wrData, r.wd);
    chk($sformatf("vec%0d.busy", idx), busy, r.bz);
    chk($sformatf("vec%0d.grantId", idx), grantId, r.g);
    chk($sformatf("vec%0d.timeoutPulse", idx), timeoutPulse, r.tp);
  endtask

  // Drive one cycle, check outputs against the model, then advance the model
  // across the coming rising edge. acc returns the requester whose byte moved.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                      input logic tf, output int acc);
    logic [3:0] exp_rdy;
    int c;
    @(negedge clk);
    reqValid = v; reqData = d; reqLast = l; txFull = tf;
    #1;
    exp_rdy = (m_owner >= 0 && !tf) ? 4'(1 << m_owner) : 4'b0000;
    chk("m.reqReady", reqReady, exp_rdy);
    chk("m.busy", busy, m_owner >= 0);
    chk("m.grantId", grantId, m_last_grant);
    chk("m.wrEn", wrEn, m_wr_en);
    chk("m.wrData", wrData, m_wr_data);
    chk("m.timeoutPulse", timeoutPulse, m_pulse);
    acc = -1;
    m_wr_en = 1'b0;
    m_pulse = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_owner < 0 && v[c]) begin
          m_owner = c; m_last_grant = c; m_idle = 0;
        end
      end
    end else if (v[m_owner] && !tf) begin
      acc = m_owner;
      m_wr_en = 1'b1;
      m_wr_data = d[8*m_owner +: 8];
      m_idle = 0;
      if (l[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (!v[m_owner]) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_pulse = 1'b1;
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  logic [7:0]  cur[4];
  int          rem[4];
  int          gap[4];
  int          acc, n;
  int          grants[$];
  logic [3:0]  vv, ll;
  logic [31:0] dd;

  initial begin
    rst = 1'b1;
    reqValid = '0; reqData = '0; reqLast = '0; txFull = 1'b0;
    model_reset();

    // Directed table: two-byte message, two contenders, long txFull stall.
    vecs.push_back(mk(4'b0001, 32'h0000_0041, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(4'b0001, 32'h0000_0041, 4'b0000, 0, 4'b0001, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(4'b0001, 32'h0000_0042, 4'b0001, 0, 4'b0001, 1, 8'h41, 1, 0, 0));
    vecs.push_back(mk(4'b0110, 32'h0021_1100, 4'b0100, 0, 4'b0000, 1, 8'h42, 0, 0, 0));
    vecs.push_back(mk(4'b0110, 32'h0021_1100, 4'b0100, 0, 4'b0010, 0, 8'h42, 1, 1, 0));
    vecs.push_back(mk(4'b0110, 32'h0021_1200, 4'b0110, 0, 4'b0010, 1, 8'h11, 1, 1, 0));
    vecs.push_back(mk(4'b0100, 32'h0021_0000, 4'b0100, 0, 4'b0000, 1, 8'h12, 0, 1, 0));
    vecs.push_back(mk(4'b0100, 32'h0021_0000, 4'b0100, 0, 4'b0100, 0, 8'h12, 1, 2, 0));
    vecs.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 1, 8'h21, 0, 2, 0));
    vecs.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h21, 0, 2, 0));
    vecs.push_back(mk(4'b0001, 32'h0000_0051, 4'b0000, 0, 4'b0000, 0, 8'h21, 0, 2, 0));
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(4'b0001, 32'h0000_0051, 4'b0000, 1, 4'b0000, 0, 8'h21, 1, 0, 0));
    vecs.push_back(mk(4'b0001, 32'h0000_0051, 4'b0000, 0, 4'b0001, 0, 8'h21, 1, 0, 0));
    vecs.push_back(mk(4'b0001, 32'h0000_0052, 4'b0001, 0, 4'b0001, 1, 8'h51, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 1, 8'h52, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h52, 0, 0, 0));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Timeout: req3 sends one non-last byte and goes quiet while req0 waits.
    do_reset();
    step(4'b1000, 32'h3300_0000, 4'b0000, 0, acc);
    step(4'b1000, 32'h3300_0000, 4'b0000, 0, acc);
    chk("tmo.first_accept", acc, 3);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0001, 32'h0000_000A, 4'b0001, 0, acc);
      n++;
      if (timeoutPulse) break;
    end
    chk("tmo.latency", n, TMO + 1);
    step(4'b0001, 32'h0000_000A, 4'b0001, 0, acc);
    chk("tmo.next_grant", grantId, 0);
    chk("tmo.next_busy", busy, 1);
    step(4'b0000, 32'h0, 4'b0000, 0, acc);

    // Reset in the middle of a req2 message.
    do_reset();
    step(4'b0100, 32'h00C1_0000, 4'b0000, 0, acc);
    step(4'b0100, 32'h00C1_0000, 4'b0000, 0, acc);
    step(4'b0100, 32'h00C2_0000, 4'b0000, 0, acc);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.reqReady", reqReady, 0);
    chk("rst.wrEn", wrEn, 0);
    chk("rst.wrData", wrData, 0);
    chk("rst.busy", busy, 0);
    chk("rst.grantId", grantId, 0);
    chk("rst.timeoutPulse", timeoutPulse, 0);
    reqValid = '0; reqData = '0; reqLast = '0; txFull = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b0110, 32'h0022_1100, 4'b0110, 0, acc);
    step(4'b0110, 32'h0022_1100, 4'b0110, 0, acc);
    chk("rst.first_grant", grantId, 1);
    step(4'b0000, 32'h0, 4'b0000, 0, acc);

    // All four requesters always valid with one-byte messages.
    do_reset();
    grants.delete();
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 32'hD3D2_D1D0 + i, 4'b1111, 0, acc);
      if (busy) grants.push_back(int'(grantId));
    end
    chk("rr.count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("rr.grant%0d", i), grants[i], i % N);

    // Randomized traffic with stalls, gaps and occasional timeouts.
    do_reset();
    for (int i = 0; i < N; i++) begin
      cur[i] = 8'($urandom);
      rem[i] = $urandom_range(1, 4);
      gap[i] = $urandom_range(0, 3);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        vv[i] = (gap[i] == 0);
        ll[i] = (rem[i] == 1);
        dd[8*i +: 8] = cur[i];
      end
      step(vv, dd, ll, ($urandom_range(0, 4) == 0), acc);
      for (int i = 0; i < N; i++) begin
        if (i == acc) begin
          cur[i] = 8'($urandom);
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          if ($urandom_range(0, 9) == 0) gap[i] = $urandom_range(1, 20);
          else if ($urandom_range(0, 2) == 0) gap[i] = $urandom_range(1, 3);
          else gap[i] = 0;
        end else if (gap[i] > 0) begin
          gap[i] = gap[i] - 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
